instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 83 ++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: registered PC plus IF/ID pipeline register, with a sticky fault trap on illegal redirects.
// Latency: one edge from programCounter to ifid_*; a taken branch inserts one bubble.
// Backpressure: stall holds PC and IF/ID; branch_taken overrides stall; FAULT ignores everything but reset.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          IMEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] imem_instruction,
    output logic [63:0] programCounter,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instruction,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetchState_t;

    localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);

    fetchState_t state;
    logic [63:0] pcPlusFour;
    logic [63:0] sequentialPc;
    logic        targetLegal;

    assign pcPlusFour   = programCounter + 64'd4;
    // Fetch wraps to the bottom of memory rather than running off the end.
    assign sequentialPc = (pcPlusFour == IMEM_LIMIT) ? 64'd0 : pcPlusFour;
    assign targetLegal  = (branch_target[1:0] == 2'b00) && (branch_target < IMEM_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= RUN;
            programCounter   <= RESET_PC;
            ifid_pc          <= 64'd0;
            ifid_instruction <= 32'd0;
            ifid_valid       <= 1'b0;
            fetch_fault      <= 1'b0;
            fetch_count      <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        ifid_valid <= 1'b0;
                        if (targetLegal) begin
                            programCounter   <= branch_target;
                            ifid_pc          <= 64'd0;
                            ifid_instruction <= 32'd0;
                        end else begin
                            // PC and IF/ID payload freeze at the point of the bad redirect.
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_pc          <= programCounter;
                        ifid_instruction <= imem_instruction;
                        ifid_valid       <= 1'b1;
                        programCounter   <= sequentialPc;
                        if (fetch_count != 32'hFFFF_FFFF) begin
                            fetch_count <= fetch_count + 32'd1;
                        end
                    end
                end
                FAULT: begin
                    ifid_valid  <= 1'b0;
                    fetch_fault <= 1'b1;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule
